// File: rtl/reg_bus_arbiter_if.sv
// Two-requester register-bus arbiter signal bundle.
// The slave modport is the arbiter side. The master modport is the side that drives the requests and the register-block responses.
interface reg_bus_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 32
);
    // requester 0
    logic                  m0_req;
    logic                  m0_req_is_wr;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wr_data;
    logic [DATA_WIDTH-1:0] m0_wr_biten;
    logic                  m0_rd_ack;
    logic                  m0_rd_err;
    logic                  m0_wr_ack;
    logic                  m0_wr_err;
    logic [DATA_WIDTH-1:0] m0_rd_data;
    logic                  m0_stall;

    // requester 1
    logic                  m1_req;
    logic                  m1_req_is_wr;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wr_data;
    logic [DATA_WIDTH-1:0] m1_wr_biten;
    logic                  m1_rd_ack;
    logic                  m1_rd_err;
    logic                  m1_wr_ack;
    logic                  m1_wr_err;
    logic [DATA_WIDTH-1:0] m1_rd_data;
    logic                  m1_stall;

    // shared register block
    logic                  o_bus_req;
    logic                  o_bus_req_is_wr;
    logic [ADDR_WIDTH-1:0] o_bus_addr;
    logic [DATA_WIDTH-1:0] o_bus_wr_data;
    logic [DATA_WIDTH-1:0] o_bus_wr_biten;
    logic                  i_bus_rd_ack;
    logic                  i_bus_rd_err;
    logic                  i_bus_wr_ack;
    logic                  i_bus_wr_err;
    logic [DATA_WIDTH-1:0] i_bus_rd_data;

    modport slave (
        input  m0_req, m0_req_is_wr, m0_addr, m0_wr_data, m0_wr_biten,
        output m0_rd_ack, m0_rd_err, m0_wr_ack, m0_wr_err, m0_rd_data, m0_stall,
        input  m1_req, m1_req_is_wr, m1_addr, m1_wr_data, m1_wr_biten,
        output m1_rd_ack, m1_rd_err, m1_wr_ack, m1_wr_err, m1_rd_data, m1_stall,
        output o_bus_req, o_bus_req_is_wr, o_bus_addr, o_bus_wr_data, o_bus_wr_biten,
        input  i_bus_rd_ack, i_bus_rd_err, i_bus_wr_ack, i_bus_wr_err, i_bus_rd_data
    );

    modport master (
        output m0_req, m0_req_is_wr, m0_addr, m0_wr_data, m0_wr_biten,
        input  m0_rd_ack, m0_rd_err, m0_wr_ack, m0_wr_err, m0_rd_data, m0_stall,
        output m1_req, m1_req_is_wr, m1_addr, m1_wr_data, m1_wr_biten,
        input  m1_rd_ack, m1_rd_err, m1_wr_ack, m1_wr_err, m1_rd_data, m1_stall,
        input  o_bus_req, o_bus_req_is_wr, o_bus_addr, o_bus_wr_data, o_bus_wr_biten,
        output i_bus_rd_ack, i_bus_rd_err, i_bus_wr_ack, i_bus_wr_err, i_bus_rd_data
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Two-port round-robin arbiter in front of a single register block.
// Each requester has one pending slot. One request is in flight at a time.
// Completion is routed back to the owner as a one-cycle pulse.
// Optional no-ack timeout: define REG_BUS_ARB_TIMEOUT_EN.
module reg_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    reg_bus_arbiter_if.slave bus
);
    localparam int unsigned NPORTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic                  is_wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wr_data;
        logic [DATA_WIDTH-1:0] wr_biten;
    } slot_t;

    // Request inputs gathered per port.
    logic [NPORTS-1:0] req_c;
    slot_t             req_slot_c [NPORTS];

    assign req_c         = {bus.m1_req, bus.m0_req};
    assign req_slot_c[0] = {bus.m0_req_is_wr, bus.m0_addr, bus.m0_wr_data, bus.m0_wr_biten};
    assign req_slot_c[1] = {bus.m1_req_is_wr, bus.m1_addr, bus.m1_wr_data, bus.m1_wr_biten};

    state_t                state_q;
    logic [NPORTS-1:0]     pend_q;
    slot_t                 slot_q [NPORTS];
    logic                  gnt_q;
    logic                  ptr_q;
    logic                  bus_req_q;
    slot_t                 bus_slot_q;
    logic [NPORTS-1:0]     rd_ack_q;
    logic [NPORTS-1:0]     rd_err_q;
    logic [NPORTS-1:0]     wr_ack_q;
    logic [NPORTS-1:0]     wr_err_q;
    logic [DATA_WIDTH-1:0] rd_data_q [NPORTS];

    logic ack_c;
    logic busy_c;
    logic accept_c;
    logic timeout_c;
    logic done_c;
    logic gnt_d;

    // Acks only count while a request is outstanding.
    assign ack_c    = bus.i_bus_rd_ack | bus.i_bus_wr_ack;
    assign busy_c   = (state_q == ISSUE) || (state_q == WAIT);
    assign accept_c = busy_c && ack_c;
    assign done_c   = accept_c || timeout_c;

    // When both ports are pending, the pointer picks one. Otherwise the single pending port wins.
    assign gnt_d = (&pend_q) ? ptr_q : pend_q[1];

`ifdef REG_BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = 8;

    logic [CNT_WIDTH-1:0] cnt_q;

    // The counter holds the number of cycles spent in flight. The ISSUE cycle counts as 1.
    // An ack in the same cycle as the limit is reached takes priority over the timeout.
    assign timeout_c = busy_c && !ack_c && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES));

    // Load on grant, then count each in-flight cycle that does not complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == IDLE) && (|pend_q)) begin
            cnt_q <= CNT_WIDTH'(1);
        end else if (busy_c && !done_c) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Per-port pending slot: capture when free, release on completion of that port.
    for (genvar g = 0; g < NPORTS; g++) begin : g_slot
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pend_q[g] <= 1'b0;
                slot_q[g] <= '0;
            end else if (done_c && (gnt_q == 1'(g))) begin
                pend_q[g] <= 1'b0;
            end else if (req_c[g] && !pend_q[g]) begin
                pend_q[g] <= 1'b1;
                slot_q[g] <= req_slot_c[g];
            end
        end
    end

    // Arbitration FSM and the registered register-block request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            ptr_q      <= 1'b0;
            bus_req_q  <= 1'b0;
            bus_slot_q <= '0;
        end else begin
            bus_req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|pend_q) begin
                        state_q    <= ISSUE;
                        gnt_q      <= gnt_d;
                        bus_req_q  <= 1'b1;
                        bus_slot_q <= slot_q[gnt_d];
                        // The pointer only moves after a contested grant.
                        if (&pend_q) begin
                            ptr_q <= ~gnt_d;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    if (done_c) begin
                        state_q    <= IDLE;
                        bus_slot_q <= '0;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // One-cycle completion pulse to the owning port. Read data is driven only with rd_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ack_q     <= '0;
            rd_err_q     <= '0;
            wr_ack_q     <= '0;
            wr_err_q     <= '0;
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
        end else begin
            rd_ack_q     <= '0;
            rd_err_q     <= '0;
            wr_ack_q     <= '0;
            wr_err_q     <= '0;
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
            if (accept_c) begin
                rd_ack_q[gnt_q]  <= bus.i_bus_rd_ack;
                rd_err_q[gnt_q]  <= bus.i_bus_rd_err;
                wr_ack_q[gnt_q]  <= bus.i_bus_wr_ack;
                wr_err_q[gnt_q]  <= bus.i_bus_wr_err;
                rd_data_q[gnt_q] <= bus.i_bus_rd_ack ? bus.i_bus_rd_data : '0;
            end else if (timeout_c) begin
                if (bus_slot_q.is_wr) begin
                    wr_ack_q[gnt_q] <= 1'b1;
                    wr_err_q[gnt_q] <= 1'b1;
                end else begin
                    rd_ack_q[gnt_q] <= 1'b1;
                    rd_err_q[gnt_q] <= 1'b1;
                end
            end
        end
    end

    assign bus.m0_rd_ack  = rd_ack_q[0];
    assign bus.m0_rd_err  = rd_err_q[0];
    assign bus.m0_wr_ack  = wr_ack_q[0];
    assign bus.m0_wr_err  = wr_err_q[0];
    assign bus.m0_rd_data = rd_data_q[0];
    assign bus.m0_stall   = pend_q[0];

    assign bus.m1_rd_ack  = rd_ack_q[1];
    assign bus.m1_rd_err  = rd_err_q[1];
    assign bus.m1_wr_ack  = wr_ack_q[1];
    assign bus.m1_wr_err  = wr_err_q[1];
    assign bus.m1_rd_data = rd_data_q[1];
    assign bus.m1_stall   = pend_q[1];

    assign bus.o_bus_req       = bus_req_q;
    assign bus.o_bus_req_is_wr = bus_slot_q.is_wr;
    assign bus.o_bus_addr      = bus_slot_q.addr;
    assign bus.o_bus_wr_data   = bus_slot_q.wr_data;
    assign bus.o_bus_wr_biten  = bus_slot_q.wr_biten;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter. It uses directed vectors and a transaction-level reference model.
// The timeout section is active when REG_BUS_ARB_TIMEOUT_EN is defined.
module tb_reg_bus_arbiter;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 32;
    localparam int          TO = 4;
`ifdef REG_BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    reg_bus_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // The model tracks the pending requests, the owner of the in-flight request, and the cycle in which the request was issued.
    bit              m_pend [2];
    logic            m_wr   [2];
    logic [AW-1:0]   m_addr [2];
    logic [DW-1:0]   m_wdat [2];
    logic [DW-1:0]   m_bite [2];
    bit              m_busy;
    bit              m_own;
    bit              m_ptr;
    int              m_issue;
    int              m_cyc;
    logic [3:0]      e_flags [2];   // rd_ack, rd_err, wr_ack, wr_err
    logic [DW-1:0]   e_rdata [2];

    function automatic void model_reset();
        m_pend[0] = 0; m_pend[1] = 0;
        m_wr[0] = 0; m_wr[1] = 0;
        m_addr[0] = '0; m_addr[1] = '0;
        m_wdat[0] = '0; m_wdat[1] = '0;
        m_bite[0] = '0; m_bite[1] = '0;
        m_busy = 0; m_own = 0; m_ptr = 0;
        m_issue = 0; m_cyc = 0;
        e_flags[0] = '0; e_flags[1] = '0;
        e_rdata[0] = '0; e_rdata[1] = '0;
    endfunction

    function automatic void model_step();
        bit np [2];
        bit nbusy;
        bit nown;
        np    = m_pend;
        nbusy = m_busy;
        nown  = m_own;
        e_flags[0] = '0; e_flags[1] = '0;
        e_rdata[0] = '0; e_rdata[1] = '0;
        if (m_busy) begin
            if (bus.i_bus_rd_ack || bus.i_bus_wr_ack) begin
                e_flags[m_own] = {bus.i_bus_rd_ack, bus.i_bus_rd_err, bus.i_bus_wr_ack, bus.i_bus_wr_err};
                e_rdata[m_own] = bus.i_bus_rd_ack ? bus.i_bus_rd_data : '0;
                np[m_own] = 0;
                nbusy = 0;
            end else if (TO_EN && (m_cyc - m_issue + 1 >= TO)) begin
                e_flags[m_own] = m_wr[m_own] ? 4'b0011 : 4'b1100;
                np[m_own] = 0;
                nbusy = 0;
            end
        end else if (m_pend[0] || m_pend[1]) begin
            if (m_pend[0] && m_pend[1]) begin
                nown  = m_ptr;
                m_ptr = !m_ptr;
            end else begin
                nown = m_pend[1];
            end
            nbusy   = 1;
            m_issue = m_cyc + 1;
        end
        if (bus.m0_req && !m_pend[0]) begin
            np[0] = 1;
            m_wr[0] = bus.m0_req_is_wr; m_addr[0] = bus.m0_addr;
            m_wdat[0] = bus.m0_wr_data; m_bite[0] = bus.m0_wr_biten;
        end
        if (bus.m1_req && !m_pend[1]) begin
            np[1] = 1;
            m_wr[1] = bus.m1_req_is_wr; m_addr[1] = bus.m1_addr;
            m_wdat[1] = bus.m1_wr_data; m_bite[1] = bus.m1_wr_biten;
        end
        m_pend = np;
        m_busy = nbusy;
        m_own  = nown;
        m_cyc++;
    endfunction

    function automatic logic [255:0] exp_bus();
        if (!m_busy) return '0;
        return 256'({(m_issue == m_cyc), m_wr[m_own], m_addr[m_own], m_wdat[m_own], m_bite[m_own]});
    endfunction

    always @(posedge rst) model_reset();

    always @(posedge clk) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Compare the model with the DUT every cycle, on the falling edge.
    always @(negedge clk) begin
        check("m0_outputs",
              256'({bus.m0_rd_ack, bus.m0_rd_err, bus.m0_wr_ack, bus.m0_wr_err, bus.m0_stall, bus.m0_rd_data}),
              256'({e_flags[0], m_pend[0], e_rdata[0]}));
        check("m1_outputs",
              256'({bus.m1_rd_ack, bus.m1_rd_err, bus.m1_wr_ack, bus.m1_wr_err, bus.m1_stall, bus.m1_rd_data}),
              256'({e_flags[1], m_pend[1], e_rdata[1]}));
        check("bus_request",
              256'({bus.o_bus_req, bus.o_bus_req_is_wr, bus.o_bus_addr, bus.o_bus_wr_data, bus.o_bus_wr_biten}),
              exp_bus());
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [255:0] all_outputs();
        return 256'({bus.m0_rd_ack, bus.m0_rd_err, bus.m0_wr_ack, bus.m0_wr_err, bus.m0_stall, bus.m0_rd_data,
                     bus.m1_rd_ack, bus.m1_rd_err, bus.m1_wr_ack, bus.m1_wr_err, bus.m1_stall, bus.m1_rd_data,
                     bus.o_bus_req, bus.o_bus_req_is_wr, bus.o_bus_addr, bus.o_bus_wr_data, bus.o_bus_wr_biten});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        bus.i_bus_rd_ack = 1'b0;
        bus.i_bus_rd_err = 1'b0;
        bus.i_bus_wr_ack = 1'b0;
        bus.i_bus_wr_err = 1'b0;
    endtask

    task automatic pulse(input bit port, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [DW-1:0] biten);
        if (!port) begin
            bus.m0_req = 1'b1; bus.m0_req_is_wr = wr; bus.m0_addr = addr;
            bus.m0_wr_data = data; bus.m0_wr_biten = biten;
        end else begin
            bus.m1_req = 1'b1; bus.m1_req_is_wr = wr; bus.m1_addr = addr;
            bus.m1_wr_data = data; bus.m1_wr_biten = biten;
        end
    endtask

    // Wait up to 20 cycles for o_bus_req. Returns the number of cycles skipped.
    task automatic wait_bus_req(output int waited);
        waited = 0;
        @(negedge clk);
        while (!bus.o_bus_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("bus_req_seen", 256'(bus.o_bus_req), 256'(1));
    endtask

    // Acknowledge the next issued request 'delay' cycles after ISSUE.
    // The task returns at the falling edge of the response cycle.
    task automatic serve(input logic [AW-1:0] addr, input int delay, input logic rd_a, input logic rd_e,
                         input logic wr_a, input logic wr_e, input logic [DW-1:0] data, output int waited);
        wait_bus_req(waited);
        check("bus_addr", 256'(bus.o_bus_addr), 256'(addr));
        repeat (delay) @(negedge clk);
        bus.i_bus_rd_ack  = rd_a;
        bus.i_bus_rd_err  = rd_e;
        bus.i_bus_wr_ack  = wr_a;
        bus.i_bus_wr_err  = wr_e;
        bus.i_bus_rd_data = data;
        step();
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        bus.m0_req = 0; bus.m0_req_is_wr = 0; bus.m0_addr = '0; bus.m0_wr_data = '0; bus.m0_wr_biten = '0;
        bus.m1_req = 0; bus.m1_req_is_wr = 0; bus.m1_addr = '0; bus.m1_wr_data = '0; bus.m1_wr_biten = '0;
        bus.i_bus_rd_ack = 0; bus.i_bus_rd_err = 0; bus.i_bus_wr_ack = 0; bus.i_bus_wr_err = 0;
        bus.i_bus_rd_data = '0;

        #1 rst = 1'b1;
        #2 check("reset_outputs_zero", all_outputs(), 256'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single read on m0. The request pulse is in cycle 0, so o_bus_req is expected in cycle 2.
        step();
        pulse(0, 1'b0, 3'd3, 32'h0, 32'h0);
        step();
        @(negedge clk);
        check("stall_after_capture", 256'(bus.m0_stall), 256'(1));
        check("no_early_bus_req", 256'(bus.o_bus_req), 256'(0));
        serve(3'd3, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, w);
        check("issue_latency", 256'(w), 256'(0));
        check("rd_ack_m0", 256'(bus.m0_rd_ack), 256'(1));
        check("rd_data_m0", 256'(bus.m0_rd_data), 256'(32'hDEADBEEF));
        check("rd_err_m0", 256'(bus.m0_rd_err), 256'(0));
        check("m1_quiet", 256'({bus.m1_rd_ack, bus.m1_rd_err, bus.m1_wr_ack, bus.m1_wr_err, bus.m1_rd_data}), 256'(0));

        // A pulse during m0's own response cycle must be captured. This one is a write, acked in ISSUE.
        pulse(0, 1'b1, 3'd5, 32'h1111_2222, 32'h0000_FFFF);
        step();
        serve(3'd5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hAAAA_5555, w);
        check("recapture_latency", 256'(w), 256'(1));
        check("wr_ack_m0", 256'(bus.m0_wr_ack), 256'(1));
        check("rd_data_gated", 256'(bus.m0_rd_data), 256'(0));

        // Two simultaneous writes: m0 is granted first, then m1.
        step();
        pulse(0, 1'b1, 3'd1, 32'h0000_0001, 32'hFFFF_FFFF);
        pulse(1, 1'b1, 3'd2, 32'h0000_0002, 32'hFFFF_FFFF);
        step();
        serve(3'd1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, w);
        check("rr_first_m0", 256'({bus.m0_wr_ack, bus.m1_wr_ack, bus.m1_stall}), 256'(3'b101));
        serve(3'd2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, w);
        check("rr_second_m1", 256'({bus.m0_wr_ack, bus.m1_wr_ack}), 256'(2'b01));

        // The next simultaneous pair: m1 is granted first.
        step();
        pulse(0, 1'b1, 3'd6, 32'h0000_0006, 32'h0000_00FF);
        pulse(1, 1'b1, 3'd7, 32'h0000_0007, 32'h0000_FF00);
        step();
        serve(3'd7, 2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, w);
        check("rr_pair2_m1", 256'({bus.m0_wr_ack, bus.m1_wr_ack}), 256'(2'b01));
        serve(3'd6, 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, w);
        check("rr_pair2_m0", 256'({bus.m0_wr_ack, bus.m1_wr_ack}), 256'(2'b10));

        // Write error on m1. A second m1 pulse arrives while m1 is stalled and must be dropped.
        step();
        pulse(1, 1'b1, 3'd2, 32'hCAFE_0000, 32'h0000_000F);
        step();
        pulse(1, 1'b1, 3'd6, 32'hBAD0_0000, 32'h0000_00F0);
        step();
        serve(3'd2, 2, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, w);
        check("wr_err_m1", 256'({bus.m1_wr_ack, bus.m1_wr_err}), 256'(2'b11));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_extra_bus_req", 256'(bus.o_bus_req), 256'(0));
        end

        // Read with error on m0.
        step();
        pulse(0, 1'b0, 3'd1, 32'h0, 32'h0);
        step();
        serve(3'd1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D, w);
        check("rd_err_m0", 256'({bus.m0_rd_ack, bus.m0_rd_err, bus.m0_rd_data}), 256'({2'b11, 32'h0BAD_F00D}));

        // An ack while the arbiter is idle is ignored.
        step();
        bus.i_bus_rd_ack = 1'b1; bus.i_bus_rd_data = 32'h1234_5678;
        step();
        @(negedge clk);
        check("idle_ack_ignored", 256'({bus.m0_rd_ack, bus.m1_rd_ack}), 256'(0));

        // Reset during WAIT clears all outputs at once. A later ack produces nothing.
        step();
        pulse(0, 1'b0, 3'd4, 32'h0, 32'h0);
        step();
        wait_bus_req(w);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("rst_all_outputs", all_outputs(), 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        bus.i_bus_rd_ack = 1'b1; bus.i_bus_rd_data = 32'h7777_7777;
        step();
        @(negedge clk);
        check("aborted_no_resp", 256'({bus.m0_rd_ack, bus.m0_rd_err, bus.m0_rd_data}), 256'(0));
        step();
        pulse(0, 1'b0, 3'd4, 32'h0, 32'h0);
        step();
        serve(3'd4, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h600D_CAFE, w);
        check("post_rst_read", 256'({bus.m0_rd_ack, bus.m0_rd_data}), 256'({1'b1, 32'h600D_CAFE}));

`ifdef REG_BUS_ARB_TIMEOUT_EN
        // No ack: the error completion arrives four cycles after ISSUE. A late ack is ignored.
        step();
        pulse(0, 1'b0, 3'd7, 32'h0, 32'h0);
        step();
        wait_bus_req(w);
        repeat (4) @(negedge clk);
        check("timeout_resp", 256'({bus.m0_rd_ack, bus.m0_rd_err, bus.m0_rd_data}), 256'({2'b11, 32'h0}));
        bus.i_bus_rd_ack = 1'b1; bus.i_bus_rd_data = 32'h5555_5555;
        step();
        @(negedge clk);
        check("late_ack_ignored", 256'({bus.m0_rd_ack, bus.m0_rd_data}), 256'(0));
`endif

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
